// File: rtl/sel_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sel_arb
//  Description : Round-robin arbiter over N valid/ready requesters. It routes
//                the winner's W-bit slice of the packed data bus into a
//                single-entry registered output stage with valid/ready.
//                Optional packet lock: define SEL_ARB_PKT_LOCK_EN to keep the
//                grant on one requester until it presents a beat with last=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sel_arb #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       i_req_vld,
  input  logic [N*W-1:0]     i_req_dat,
  input  logic [N-1:0]       i_req_last,
  output logic [N-1:0]       o_req_rdy,
  output logic               o_out_vld,
  output logic [W-1:0]       o_out_dat,
  output logic [IDX_W-1:0]   o_out_idx,
  input  logic               i_out_rdy
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

  logic               r_out_vld;
  logic [W-1:0]       r_out_dat;
  logic [IDX_W-1:0]   r_out_idx;
  logic [IDX_W-1:0]   r_ptr;

  logic               w_load;
  logic [N-1:0]       w_elig;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [W-1:0]       w_win_dat;
  logic [IDX_W-1:0]   w_ptr_inc;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [W-1:0]       w_beat [N];

  // Output stage can take a new beat when empty or when its beat retires now
  assign w_load = !r_out_vld || i_out_rdy;

  // Slice the packed bus into one beat per requester
  for (genvar k = 0; k < N; k++) begin : g_beat
    assign w_beat[k] = i_req_dat[k*W +: W];
  end

`ifdef SEL_ARB_PKT_LOCK_EN
  logic               r_lock;
  logic [IDX_W-1:0]   r_lock_idx;

  // While a packet is in flight only its owner may be considered
  always_comb begin
    w_elig = i_req_vld;
    if (r_lock) begin
      w_elig             = '0;
      w_elig[r_lock_idx] = i_req_vld[r_lock_idx];
    end
  end

  // Pointer only moves once the packet has finished
  assign w_ptr_nxt = i_req_last[w_win] ? w_ptr_inc : r_ptr;

  // Lock is taken on a non-last beat and released on the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_load && w_found) begin
      if (i_req_last[w_win]) begin
        r_lock <= 1'b0;
      end else begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_win;
      end
    end
  end
`else
  // End-of-packet flags have no effect without packet lock
  logic w_unused_last;
  assign w_unused_last = ^i_req_last;

  assign w_elig    = i_req_vld;
  assign w_ptr_nxt = w_ptr_inc;
`endif

  // Scan from the pointer upward, wrapping modulo N, for the first eligible
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    w_found   = 1'b0;
    w_win     = '0;
    w_win_dat = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N) begin
        j = j - N;
      end
      jj = j[IDX_W-1:0];
      if (!w_found && w_elig[jj]) begin
        w_found   = 1'b1;
        w_win     = jj;
        w_win_dat = w_beat[jj];
      end
    end
  end

  // Next round-robin start point is the slot just after the winner
  assign w_ptr_inc = (w_win == c_last_idx) ? '0 : w_win + 1'b1;

  // Ready goes only to the winner, and never while reset is asserted
  for (genvar k = 0; k < N; k++) begin : g_rdy
    assign o_req_rdy[k] = !rst && w_load && w_found && (w_win == IDX_W'(k));
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_idx <= '0;
      r_ptr     <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_out_vld <= 1'b1;
        r_out_dat <= w_win_dat;
        r_out_idx <= w_win;
        r_ptr     <= w_ptr_nxt;
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign o_out_vld = r_out_vld;
  assign o_out_dat = r_out_dat;
  assign o_out_idx = r_out_idx;

endmodule
`default_nettype wire

// File: tb/tb_sel_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sel_arb
//  Description : Self-checking bench for sel_arb (N=4 main instance plus an
//                N=3 instance for non-power-of-two wrap). Randomised traffic
//                is compared against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld, req_last, req_rdy;
  logic [N*W-1:0] req_dat;
  logic           out_vld, out_rdy;
  logic [W-1:0]   out_dat;
  logic [1:0]     out_idx;

  logic           rst3;
  logic [2:0]     vld3, last3, rdy3;
  logic [3*W-1:0] dat3;
  logic           ovld3, ordy3;
  logic [W-1:0]   odat3;
  logic [1:0]     oidx3;

  always #5 clk = ~clk;

  sel_arb #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .i_req_vld(req_vld), .i_req_dat(req_dat), .i_req_last(req_last),
    .o_req_rdy(req_rdy),
    .o_out_vld(out_vld), .o_out_dat(out_dat), .o_out_idx(out_idx),
    .i_out_rdy(out_rdy)
  );

  sel_arb #(.N(3), .W(W)) dut3 (
    .clk(clk), .rst(rst3),
    .i_req_vld(vld3), .i_req_dat(dat3), .i_req_last(last3),
    .o_req_rdy(rdy3),
    .o_out_vld(ovld3), .o_out_dat(odat3), .o_out_idx(oidx3),
    .i_out_rdy(ordy3)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int         m_ptr, m_lidx, m_idx;
  bit         m_lock, m_vld;
  logic [W-1:0] m_dat;
  int         g;
  logic [N-1:0] last_rdy;
  int         cnt2;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Winner by the round-robin rule, or -1 when nothing is granted
  function automatic int pick();
    int k;
    if (rst) return -1;
    if (m_vld && !out_rdy) return -1;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (req_vld[k] && (!m_lock || k == m_lidx)) return k;
    end
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] erdy;
    #1;
    g = pick();
    erdy = (g >= 0) ? N'(1 << g) : '0;
    last_rdy = req_rdy;
    check("req_rdy", {60'd0, req_rdy}, {60'd0, erdy});
    @(posedge clk);
    #1;
    if (rst) begin
      m_vld = 0; m_dat = '0; m_idx = 0; m_ptr = 0; m_lock = 0; m_lidx = 0;
    end else if (g >= 0) begin
      m_vld = 1;
      m_dat = req_dat[g*W +: W];
      m_idx = g;
`ifdef SEL_ARB_PKT_LOCK_EN
      if (req_last[g]) begin
        m_lock = 0;
        m_ptr  = (g + 1) % N;
      end else begin
        m_lock = 1;
        m_lidx = g;
      end
`else
      m_ptr = (g + 1) % N;
`endif
    end else if (!m_vld || out_rdy) begin
      m_vld = 0;
    end
    check("out_vld", {63'd0, out_vld}, {63'd0, m_vld});
    check("out_dat", {32'd0, out_dat}, {32'd0, m_dat});
    check("out_idx", {62'd0, out_idx}, 64'(m_idx));
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic r, input logic ordy);
    @(negedge clk);
    req_vld = v;
    req_last = l;
    rst = r;
    out_rdy = ordy;
    step();
  endtask

  logic         pend  [N];
  logic [W-1:0] rdat  [N];
  logic         rlast [N];

`ifdef SEL_ARB_PKT_LOCK_EN
  localparam int PKT_LEN = 4;
  int pkt_exp [5] = '{2, 2, 2, 0, 0};
`else
  localparam int PKT_LEN = 5;
  int pkt_exp [5] = '{2, 0, 2, 0, 2};
`endif
  int n3_wrap [4] = '{0, 1, 2, 0};

  initial begin
    logic [N-1:0] v, l;
    rst = 1; req_vld = '0; req_last = '0; req_dat = '0; out_rdy = 1;
    rst3 = 1; vld3 = '0; last3 = '1; dat3 = '0; ordy3 = 1;
    m_vld = 0; m_dat = '0; m_idx = 0; m_ptr = 0; m_lock = 0; m_lidx = 0;

    // Reset state
    drive('0, '0, 1, 1);
    drive('0, '0, 1, 1);
    check("rst_idx", {62'd0, out_idx}, 64'd0);

    // Full request set rotates 0,1,2,3 with no bubbles
    req_dat = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    drive('0, '0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(4'hF, 4'hF, 0, 1);
      check("rr_idx", {62'd0, out_idx}, 64'(i % 4));
      check("rr_vld", {63'd0, out_vld}, 64'd1);
    end

    // Stall holds the beat; first ready cycle retires it and loads the next
    drive('0, '0, 1, 1);
    req_dat[63:32] = 32'hDEAD_BEEF;
    drive(4'b0010, 4'hF, 0, 1);
    req_dat[31:0] = 32'h0A0A_0A0A;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 4'hF, 0, 0);
      check("stall_dat", {32'd0, out_dat}, 64'hDEAD_BEEF);
      check("stall_idx", {62'd0, out_idx}, 64'd1);
      check("stall_rdy", {60'd0, last_rdy}, 64'd0);
    end
    drive(4'b0001, 4'hF, 0, 1);
    check("unstall_idx", {62'd0, out_idx}, 64'd0);
    check("unstall_dat", {32'd0, out_dat}, 64'h0A0A_0A0A);

    // Reset while stalled drops the beat and clears the pointer
    drive(4'b0010, 4'hF, 0, 1);
    drive(4'b0001, 4'hF, 0, 0);
    drive(4'b0001, 4'hF, 1, 0);
    check("rst_stall_vld", {63'd0, out_vld}, 64'd0);
    check("rst_stall_idx", {62'd0, out_idx}, 64'd0);
    drive(4'b0110, 4'hF, 0, 1);
    check("post_rst_ptr", {62'd0, out_idx}, 64'd1);
    drive(4'b0100, 4'hF, 0, 1);
    drive(4'b1000, 4'hF, 0, 1);
    check("post_rst_idx3", {62'd0, out_idx}, 64'd3);

    // Packet from requester 2 (last on 3rd beat) against requester 0
    drive('0, '0, 1, 1);
    drive(4'b0010, 4'hF, 0, 1);
    cnt2 = 0;
    for (int i = 0; i < PKT_LEN; i++) begin
      l = {1'b0, cnt2 == 2, 1'b0, 1'b1};
      drive(4'b0101, l, 0, 1);
      if (g == 2) cnt2++;
      check("pkt_idx", {62'd0, out_idx}, 64'(pkt_exp[i]));
    end

    // Requester 2 bubbles mid-packet
    drive('0, '0, 1, 1);
    drive(4'b0010, 4'hF, 0, 1);
    drive(4'b0101, 4'b0001, 0, 1);
    drive(4'b0001, 4'b0001, 0, 1);
`ifdef SEL_ARB_PKT_LOCK_EN
    check("bubble_rdy", {60'd0, last_rdy}, 64'd0);
`else
    check("bubble_rdy", {60'd0, last_rdy}, 64'd1);
`endif
    drive(4'b0101, 4'b0001, 0, 1);
    drive(4'b0101, 4'b0101, 0, 1);
    drive(4'b0101, 4'b0001, 0, 1);

    // Randomised traffic with protocol-respecting requesters
    for (int k = 0; k < N; k++) pend[k] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(1, 0) == 1) begin
          pend[k]  = 1;
          rdat[k]  = $urandom;
          rlast[k] = ($urandom_range(2, 0) == 0);
        end
      end
      for (int k = 0; k < N; k++) begin
        v[k] = pend[k];
        l[k] = rlast[k];
        req_dat[k*W +: W] = rdat[k];
      end
      drive(v, l, $urandom_range(60, 0) == 0, $urandom_range(3, 0) != 0);
      if (g >= 0) pend[g] = 0;
    end

    // N=3: modulo-N wrap
    dat3 = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    @(negedge clk);
    rst3 = 0;
    vld3 = 3'b101;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("n3_alt_idx", {62'd0, oidx3}, (i % 2 == 1) ? 64'd2 : 64'd0);
      check("n3_alt_vld", {63'd0, ovld3}, 64'd1);
    end
    @(negedge clk);
    vld3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("n3_wrap_idx", {62'd0, oidx3}, 64'(n3_wrap[i]));
    end
    check("n3_wrap_dat", {32'd0, odat3}, 64'hA0A0_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
